// File: rtl/pipe_pkg.sv
// Shared pipeline constants, payload layout and helpers for the ID/EXE register.
package pipe_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_RADDR_W   = 5;
  localparam int DEF_ALUOP_W   = 8;
  localparam int DEF_ALUTYPE_W = 3;

  // Packed order MSB..LSB: alutype, aluop, src1, src2, wa, wreg, mreg, din, whilo, ret_addr
  function automatic int payload_w(int dw, int rw, int ow, int tw);
    return tw + ow + 4*dw + rw + 3;
  endfunction

  localparam int IDEXE_PAYLOAD_W = payload_w(DEF_DATA_W, DEF_RADDR_W, DEF_ALUOP_W, DEF_ALUTYPE_W);

  localparam int RET_OFF     = 0;
  localparam int WHILO_OFF   = RET_OFF + DEF_DATA_W;
  localparam int DIN_OFF     = WHILO_OFF + 1;
  localparam int MREG_OFF    = DIN_OFF + DEF_DATA_W;
  localparam int WREG_OFF    = MREG_OFF + 1;
  localparam int WA_OFF      = WREG_OFF + 1;
  localparam int SRC2_OFF    = WA_OFF + DEF_RADDR_W;
  localparam int SRC1_OFF    = SRC2_OFF + DEF_DATA_W;
  localparam int ALUOP_OFF   = SRC1_OFF + DEF_DATA_W;
  localparam int ALUTYPE_OFF = ALUOP_OFF + DEF_ALUOP_W;

  typedef struct packed {
    logic [DEF_ALUTYPE_W-1:0] alutype;
    logic [DEF_ALUOP_W-1:0]   aluop;
    logic [DEF_DATA_W-1:0]    src1;
    logic [DEF_DATA_W-1:0]    src2;
    logic [DEF_RADDR_W-1:0]   wa;
    logic                     wreg;
    logic                     mreg;
    logic [DEF_DATA_W-1:0]    din;
    logic                     whilo;
    logic [DEF_DATA_W-1:0]    ret_addr;
  } idexe_payload_t;

endpackage

// File: rtl/idexe_skid_reg_if.sv
// Decode-to-execute handshake bundle; slave is the pipeline register's view.
interface idexe_skid_reg_if
  import pipe_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int RADDR_W   = DEF_RADDR_W,
  parameter int ALUOP_W   = DEF_ALUOP_W,
  parameter int ALUTYPE_W = DEF_ALUTYPE_W
);
  logic                 flush;
  logic                 id_valid;
  logic                 id_ready;
  logic [ALUTYPE_W-1:0] id_alutype;
  logic [ALUOP_W-1:0]   id_aluop;
  logic [DATA_W-1:0]    id_src1;
  logic [DATA_W-1:0]    id_src2;
  logic [RADDR_W-1:0]   id_wa;
  logic                 id_wreg;
  logic                 id_mreg;
  logic [DATA_W-1:0]    id_din;
  logic                 id_whilo;
  logic [DATA_W-1:0]    id_ret_addr;
  logic                 exe_valid;
  logic                 exe_ready;
  logic [ALUTYPE_W-1:0] exe_alutype;
  logic [ALUOP_W-1:0]   exe_aluop;
  logic [DATA_W-1:0]    exe_src1;
  logic [DATA_W-1:0]    exe_src2;
  logic [RADDR_W-1:0]   exe_wa;
  logic                 exe_wreg;
  logic                 exe_mreg;
  logic [DATA_W-1:0]    exe_din;
  logic                 exe_whilo;
  logic [DATA_W-1:0]    exe_ret_addr;

  modport slave (
    input  flush, id_valid, id_alutype, id_aluop, id_src1, id_src2, id_wa,
           id_wreg, id_mreg, id_din, id_whilo, id_ret_addr, exe_ready,
    output id_ready, exe_valid, exe_alutype, exe_aluop, exe_src1, exe_src2,
           exe_wa, exe_wreg, exe_mreg, exe_din, exe_whilo, exe_ret_addr
  );

  modport master (
    output flush, id_valid, id_alutype, id_aluop, id_src1, id_src2, id_wa,
           id_wreg, id_mreg, id_din, id_whilo, id_ret_addr, exe_ready,
    input  id_ready, exe_valid, exe_alutype, exe_aluop, exe_src1, exe_src2,
           exe_wa, exe_wreg, exe_mreg, exe_din, exe_whilo, exe_ret_addr
  );
endinterface

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer: main entry drives the output, skid entry catches
// the one transfer accepted while the output stalls. Input ready is registered.
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         in_vld_i,
  output logic         in_rdy_o,
  input  logic [W-1:0] in_dat_i,
  output logic         out_vld_o,
  input  logic         out_rdy_i,
  output logic [W-1:0] out_dat_o
);
  logic         m_vld_q, m_vld_d, s_vld_q, s_vld_d;
  logic [W-1:0] m_dat_q, m_dat_d, s_dat_q, s_dat_d;
  logic         in_xfer, out_xfer;

  assign in_rdy_o  = ~s_vld_q;
  assign out_vld_o = m_vld_q;
  assign out_dat_o = m_dat_q;
  assign in_xfer   = in_vld_i & ~s_vld_q;
  assign out_xfer  = m_vld_q & out_rdy_i;

  always_comb begin
    m_vld_d = m_vld_q;
    s_vld_d = s_vld_q;
    m_dat_d = m_dat_q;
    s_dat_d = s_dat_q;
    if (flush_i) begin
      m_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (!m_vld_q) begin
      if (in_xfer) begin
        m_dat_d = in_dat_i;
        m_vld_d = 1'b1;
      end
    end else if (out_xfer) begin
      if (s_vld_q) begin
        m_dat_d = s_dat_q;
        s_vld_d = 1'b0;
      end else if (in_xfer) begin
        m_dat_d = in_dat_i;
      end else begin
        m_vld_d = 1'b0;
      end
    end else if (in_xfer) begin
      // Output stalled: park the newer instruction behind M
      s_dat_d = in_dat_i;
      s_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld_q <= 1'b0;
      s_vld_q <= 1'b0;
      m_dat_q <= '0;
      s_dat_q <= '0;
    end else begin
      m_vld_q <= m_vld_d;
      s_vld_q <= s_vld_d;
      m_dat_q <= m_dat_d;
      s_dat_q <= s_dat_d;
    end
  end
endmodule

// File: rtl/idexe_skid_reg.sv
// MIPS32 ID/EXE pipeline register with valid/ready, flush and a 2-entry skid buffer.
// Optional stall/flush counters when IDEXE_PERF_CNT_EN is defined.
module idexe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int RADDR_W   = DEF_RADDR_W,
  parameter int ALUOP_W   = DEF_ALUOP_W,
  parameter int ALUTYPE_W = DEF_ALUTYPE_W
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef IDEXE_PERF_CNT_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
`endif
  idexe_skid_reg_if.slave bus
);
  localparam int PW = payload_w(DATA_W, RADDR_W, ALUOP_W, ALUTYPE_W);

  logic [PW-1:0] in_dat, out_dat;
  logic          m_vld, wreg_p, mreg_p, whilo_p;

  assign in_dat = {bus.id_alutype, bus.id_aluop, bus.id_src1, bus.id_src2, bus.id_wa,
                   bus.id_wreg, bus.id_mreg, bus.id_din, bus.id_whilo, bus.id_ret_addr};

  pipe_skid_buf #(.W(PW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (bus.flush),
    .in_vld_i  (bus.id_valid),
    .in_rdy_o  (bus.id_ready),
    .in_dat_i  (in_dat),
    .out_vld_o (m_vld),
    .out_rdy_i (bus.exe_ready),
    .out_dat_o (out_dat)
  );

  assign {bus.exe_alutype, bus.exe_aluop, bus.exe_src1, bus.exe_src2, bus.exe_wa,
          wreg_p, mreg_p, bus.exe_din, whilo_p, bus.exe_ret_addr} = out_dat;

  // Side-effect enables are masked so a bubble can never commit state
  assign bus.exe_valid = m_vld;
  assign bus.exe_wreg  = wreg_p  & m_vld;
  assign bus.exe_mreg  = mreg_p  & m_vld;
  assign bus.exe_whilo = whilo_p & m_vld;

`ifdef IDEXE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  // s_vld implies m_vld, so m_vld alone marks an occupied stage
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (m_vld && !bus.exe_ready && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
    if (bus.flush && m_vld && flush_cnt_q != '1)      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif
endmodule
